// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package reg_file_pkg;

  typedef enum logic {CLEAR, RUN} rf_state_t;

  localparam int RF_XLEN_DEFAULT  = 32;
  localparam int RF_NREGS_DEFAULT = 32;

endpackage

// File: rtl/reg_file_mp_rd.sv
// One read port: zero-register/clear masking plus same-cycle write forwarding
// when REG_BYPASS_EN is defined.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int XLEN = RF_XLEN_DEFAULT,
  parameter int AW   = 5
) (
  input  logic            run,
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] ram_data,
  input  logic            en0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            en1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  output logic [XLEN-1:0] rdata_c
);

`ifdef REG_BYPASS_EN
  // Port 1 is checked last so the load return wins over write-back.
  always_comb begin
    rdata_c = '0;
    if (run && raddr != '0) begin
      rdata_c = ram_data;
      if (en0 && wa0 == raddr) rdata_c = wd0;
      if (en1 && wa1 == raddr) rdata_c = wd1;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{en0, wa0, wd0, en1, wa1, wd1};

  always_comb begin
    rdata_c = '0;
    if (run && raddr != '0) rdata_c = ram_data;
  end
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with x0 hardwired to zero and a post-reset clear
// sequencer. Define REG_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN_DEFAULT,
  parameter  int NREGS = RF_NREGS_DEFAULT,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en0,
  input  logic [AW-1:0]     wa0,
  input  logic [XLEN-1:0]   wd0,
  input  logic              en1,
  input  logic [AW-1:0]     wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic              ready,
  output logic              wr_conflict
);

  rf_state_t       state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] ram [NREGS];
  logic            run;

  assign run = (state == RUN);

  // Sequencer and status flags; ready tracks entry into RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: wr_conflict <= en0 && en1 && (wa0 == wa1) && (wa0 != '0);
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset of its own; the sequencer zeroes it entry by entry.
  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        ram[clr_idx] <= '0;
      end else begin
        if (en0 && wa0 != '0) ram[wa0] <= wd0;
        if (en1 && wa1 != '0) ram[wa1] <= wd1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_rd (
      .run      (run),
      .raddr    (ra),
      .ram_data (ram[ra]),
      .en0      (en0),
      .wa0      (wa0),
      .wd0      (wd0),
      .en1      (en1),
      .wa1      (wa1),
      .wd1      (wd1),
      .rdata_c  (rdata[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: clear timing, table-driven write/read vectors,
// and a mid-run reset sequence. Expectations follow REG_BYPASS_EN when defined.
module tb_reg_file_mp;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int NREGS = 32;

  logic        clk, rst;
  logic        en0, en1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        ready, wr_conflict;

  int errors = 0;
  int checks = 0;

  reg_file_mp dut (
    .clk         (clk),
    .rst         (rst),
    .en0         (en0),
    .wa0         (wa0),
    .wd0         (wd0),
    .en1         (en1),
    .wa1         (wa1),
    .wd1         (wd1),
    .raddr       (raddr),
    .rdata       (rdata),
    .ready       (ready),
    .wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        en1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        conf;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en0 = 1'b0; wa0 = '0; wd0 = '0;
    en1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  // Runs the clear window, attempting writes throughout; they must be ignored.
  task automatic clear_window();
    for (int k = 1; k <= NREGS; k++) begin
      en0 = 1'b1; wa0 = 5'(k); wd0 = 32'hC0DE_0000 | 32'(k);
      en1 = 1'b1; wa1 = 5'(k + 1); wd1 = 32'hBEEF_0000 | 32'(k);
      raddr = {5'(k + 1), 5'(k)};
      #1;
      chk($sformatf("clr_rd0_%0d", k), rdata[31:0], 32'h0);
      chk($sformatf("clr_rd1_%0d", k), rdata[63:32], 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("clr_ready_%0d", k), {31'h0, ready}, {31'h0, (k == NREGS)});
    end
    idle();
  endtask

  initial begin
    idle();
    raddr = '0;
    rst   = 1'b1;

    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,
               5'd5,  5'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
               5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 1'b0};
    vt[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,
               5'd0,  5'd5,  32'h0, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
               5'd0,  5'd0,  32'h0, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 5'd7,  32'h11, 1'b1, 5'd7, 32'h22,
               5'd7,  5'd5,  BYP ? 32'h22 : 32'h0, 32'hDEADBEEF, 1'b1};
    vt[5]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
               5'd7,  5'd7,  32'h22, 32'h22, 1'b0};
    vt[6]  = '{1'b1, 5'd9,  32'hABCD, 1'b0, 5'd0, 32'h0,
               5'd9,  5'd9,  BYP ? 32'hABCD : 32'h0, BYP ? 32'hABCD : 32'h0, 1'b0};
    vt[7]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
               5'd9,  5'd7,  32'hABCD, 32'h22, 1'b0};
    vt[8]  = '{1'b1, 5'd10, 32'hA0A0, 1'b1, 5'd11, 32'hB1B1,
               5'd10, 5'd11, BYP ? 32'hA0A0 : 32'h0, BYP ? 32'hB1B1 : 32'h0, 1'b0};
    vt[9]  = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
               5'd10, 5'd11, 32'hA0A0, 32'hB1B1, 1'b0};
    vt[10] = '{1'b1, 5'd0,  32'h1, 1'b1, 5'd0, 32'h2,
               5'd0,  5'd10, 32'h0, 32'hA0A0, 1'b0};
    vt[11] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd31, 32'hFFFFFFFF,
               5'd31, 5'd11, BYP ? 32'hFFFFFFFF : 32'h0, 32'hB1B1, 1'b0};
    vt[12] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
               5'd31, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF, 1'b0};
    vt[13] = '{1'b1, 5'd5,  32'h1234, 1'b1, 5'd5, 32'h5678,
               5'd5,  5'd5,  BYP ? 32'h5678 : 32'hDEADBEEF, BYP ? 32'h5678 : 32'hDEADBEEF, 1'b1};
    vt[14] = '{1'b1, 5'd3,  32'h55, 1'b0, 5'd0, 32'h0,
               5'd5,  5'd3,  32'h5678, BYP ? 32'h55 : 32'h0, 1'b0};
    vt[15] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
               5'd3,  5'd5,  32'h55, 32'h5678, 1'b0};

    // Reset edge.
    tick();
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_conflict", {31'h0, wr_conflict}, 32'h0);
    rst = 1'b0;
    clear_window();

    // Every address reads zero once the array is clean.
    for (int a = 0; a < NREGS; a++) begin
      raddr = {5'(NREGS - 1 - a), 5'(a)};
      #1;
      chk($sformatf("post_clr_rd0_%0d", a), rdata[31:0], 32'h0);
      chk($sformatf("post_clr_rd1_%0d", a), rdata[63:32], 32'h0);
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      en0 = vt[i].en0; wa0 = vt[i].wa0; wd0 = vt[i].wd0;
      en1 = vt[i].en1; wa1 = vt[i].wa1; wd1 = vt[i].wd1;
      raddr = {vt[i].ra1, vt[i].ra0};
      #1;
      chk($sformatf("vec%0d_rd0", i), rdata[31:0], vt[i].rd0);
      chk($sformatf("vec%0d_rd1", i), rdata[63:32], vt[i].rd1);
      tick();
      idle();
      chk($sformatf("vec%0d_conflict", i), {31'h0, wr_conflict}, {31'h0, vt[i].conf});
      chk($sformatf("vec%0d_ready", i), {31'h0, ready}, 32'h1);
    end

    // Reset in RUN with a colliding dual write on the same edge: write dropped.
    en0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66;
    en1 = 1'b1; wa1 = 5'd6; wd1 = 32'h77;
    rst = 1'b1;
    tick();
    idle();
    chk("midrst_ready", {31'h0, ready}, 32'h0);
    chk("midrst_conflict", {31'h0, wr_conflict}, 32'h0);
    raddr = {5'd5, 5'd3};
    #1;
    chk("midrst_rd0_gated", rdata[31:0], 32'h0);
    chk("midrst_rd1_gated", rdata[63:32], 32'h0);
    rst = 1'b0;
    clear_window();

    raddr = {5'd5, 5'd3};
    #1;
    chk("after_clr_reg3", rdata[31:0], 32'h0);
    chk("after_clr_reg5", rdata[63:32], 32'h0);
    raddr = {5'd31, 5'd6};
    #1;
    chk("after_clr_reg6", rdata[31:0], 32'h0);
    chk("after_clr_reg31", rdata[63:32], 32'h0);

    // Write path still works after the second clear.
    en0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1357;
    tick();
    idle();
    raddr = {5'd0, 5'd3};
    #1;
    chk("rerun_reg3", rdata[31:0], 32'h1357);
    chk("rerun_reg0", rdata[63:32], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
